// File: rtl/i281_code_loader.sv
// i281 code loader: receives a framed byte stream, stages instruction words
// in a local buffer and commits them to code memory after a valid checksum.
// cpu_hold keeps the CPU stalled from frame header until commit or rejection.
module i281_code_loader #(
    parameter int          DEPTH    = 16,
    parameter logic [7:0]  HDR_BYTE = 8'hA5,
    parameter int          TIMEOUT  = 1024
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_rx_valid,
    input  logic [7:0]               i_rx_data,
    output logic                     o_rx_ready,
    output logic                     o_wr_en,
    output logic [$clog2(DEPTH)-1:0] o_wr_addr,
    output logic [15:0]              o_wr_data,
    output logic                     o_cpu_hold,
    output logic                     o_load_done,
    output logic                     o_load_err,
    output logic [1:0]               o_err_code
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_CNT, S_ADR, S_DHI, S_DLO, S_CSM, S_COMMIT
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [AW-1:0]   r_start;
    logic [AW-1:0]   r_idx;
    logic [CW-1:0]   r_k;
    logic [7:0]      r_hi;
    logic [7:0]      r_sum;
    logic [TW-1:0]   r_idle;
    logic            r_rx_ready;
    logic            r_wr_en;
    logic [AW-1:0]   r_wr_addr;
    logic [15:0]     r_wr_data;
    logic            r_cpu_hold;
    logic            r_load_done;
    logic            r_load_err;
    logic [1:0]      r_err_code;
    logic [15:0]     r_buf [DEPTH];

    logic            w_xfer;
    logic            w_in_frame;
    logic            w_timeout;
    logic [7:0]      w_sum_next;

    assign w_xfer     = i_rx_valid & r_rx_ready;
    assign w_in_frame = (r_state == S_CNT) || (r_state == S_ADR) || (r_state == S_DHI) ||
                        (r_state == S_DLO) || (r_state == S_CSM);
    assign w_timeout  = w_in_frame && !w_xfer && (r_idle == TW'(TIMEOUT - 1));
    assign w_sum_next = r_sum + i_rx_data;

    // Staging buffer: word k is written when its LO byte arrives.
    always_ff @(posedge i_clk) begin
        if (r_state == S_DLO && w_xfer) begin
            r_buf[r_idx] <= {r_hi, i_rx_data};
        end
    end

    // Frame FSM with registered outputs; the buffer is read one word per COMMIT cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_start     <= '0;
            r_idx       <= '0;
            r_k         <= '0;
            r_hi        <= '0;
            r_sum       <= '0;
            r_idle      <= '0;
            r_rx_ready  <= 1'b1;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_cpu_hold  <= 1'b0;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
            r_err_code  <= 2'b00;
        end else begin
            r_wr_en     <= 1'b0;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;

            if (w_timeout) begin
                r_state    <= S_IDLE;
                r_load_err <= 1'b1;
                r_err_code <= 2'b11;
                r_cpu_hold <= 1'b0;
            end else if (w_in_frame && !w_xfer) begin
                r_idle <= r_idle + 1'b1;
            end else begin
                r_idle <= '0;
                case (r_state)
                    S_IDLE: begin
                        // Anything but the header is dropped while idle.
                        if (w_xfer && i_rx_data == HDR_BYTE) begin
                            r_state    <= S_CNT;
                            r_cpu_hold <= 1'b1;
                            r_err_code <= 2'b00;
                            r_sum      <= '0;
                        end
                    end
                    S_CNT: begin
                        if (i_rx_data == 8'd0 || i_rx_data > DEPTH_B) begin
                            r_state    <= S_IDLE;
                            r_load_err <= 1'b1;
                            r_err_code <= 2'b01;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_cnt   <= i_rx_data[CW-1:0];
                            r_sum   <= w_sum_next;
                            r_state <= S_ADR;
                        end
                    end
                    S_ADR: begin
                        r_start <= i_rx_data[AW-1:0];
                        r_sum   <= w_sum_next;
                        r_idx   <= '0;
                        r_state <= S_DHI;
                    end
                    S_DHI: begin
                        r_hi    <= i_rx_data;
                        r_sum   <= w_sum_next;
                        r_state <= S_DLO;
                    end
                    S_DLO: begin
                        r_sum <= w_sum_next;
                        if (CW'(r_idx) + 1'b1 == r_cnt) begin
                            r_state <= S_CSM;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= S_DHI;
                        end
                    end
                    S_CSM: begin
                        if (w_sum_next == 8'd0) begin
                            r_state    <= S_COMMIT;
                            r_rx_ready <= 1'b0;
                            r_k        <= '0;
                        end else begin
                            r_state    <= S_IDLE;
                            r_load_err <= 1'b1;
                            r_err_code <= 2'b10;
                            r_cpu_hold <= 1'b0;
                        end
                    end
                    S_COMMIT: begin
                        // Address wraps naturally at the memory size.
                        if (r_k == r_cnt) begin
                            r_state     <= S_IDLE;
                            r_load_done <= 1'b1;
                            r_cpu_hold  <= 1'b0;
                            r_rx_ready  <= 1'b1;
                        end else begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= r_start + r_k[AW-1:0];
                            r_wr_data <= r_buf[r_k[AW-1:0]];
                            r_k       <= r_k + 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_rx_ready  = r_rx_ready;
    assign o_wr_en     = r_wr_en;
    assign o_wr_addr   = r_wr_addr;
    assign o_wr_data   = r_wr_data;
    assign o_cpu_hold  = r_cpu_hold;
    assign o_load_done = r_load_done;
    assign o_load_err  = r_load_err;
    assign o_err_code  = r_err_code;
endmodule

// File: tb/tb_i281_code_loader.sv
// Testbench for i281_code_loader: table of complete frames plus hand-written
// sequences for idle timeout and reset during COMMIT.
module tb_i281_code_loader;
    localparam int TIMEOUT = 1024;

    logic        clk;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [1:0]  err_code;

    i281_code_loader #(.DEPTH(16), .HDR_BYTE(8'hA5), .TIMEOUT(TIMEOUT)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rx_valid  (rx_valid),
        .i_rx_data   (rx_data),
        .o_rx_ready  (rx_ready),
        .o_wr_en     (wr_en),
        .o_wr_addr   (wr_addr),
        .o_wr_data   (wr_data),
        .o_cpu_hold  (cpu_hold),
        .o_load_done (load_done),
        .o_load_err  (load_err),
        .o_err_code  (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor on the falling edge: log writes and pulses.
    logic [3:0]  mon_addr [$];
    logic [15:0] mon_data [$];
    int          mon_cyc  [$];
    int          done_cnt = 0;
    int          err_cnt  = 0;
    always @(negedge clk) begin
        if (wr_en) begin
            mon_addr.push_back(wr_addr);
            mon_data.push_back(wr_data);
            mon_cyc.push_back(cyc);
        end
        if (load_done) done_cnt <= done_cnt + 1;
        if (load_err)  err_cnt  <= err_cnt + 1;
    end

    int tests = 0;
    int fails = 0;
    int xfer_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        guard = 0;
        while (!rx_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("rx_ready_wait", 32'(rx_ready), 32'd1);
        @(posedge clk);
        #1;
        xfer_cyc = cyc;
        rx_valid = 1'b0;
    endtask

    typedef struct packed {
        logic [4:0]        nb;
        logic [19:0][7:0]  b;     // b[nb-1] is sent first
        logic              ok;
        logic [1:0]        code;
        logic [1:0]        nwr;
        logic [1:0][3:0]   wa;
        logic [1:0][15:0]  wd;
    } vec_t;

    vec_t vecs [6];

    task automatic run_vec(input vec_t v, input int id);
        int wbase, dbase, ebase, guard;
        wbase = mon_addr.size();
        dbase = done_cnt;
        ebase = err_cnt;
        for (int i = 0; i < int'(v.nb); i++) send_byte(v.b[int'(v.nb) - 1 - i]);
        guard = 0;
        while (done_cnt == dbase && err_cnt == ebase && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        chk($sformatf("v%0d_done", id), 32'(done_cnt - dbase), 32'(v.ok));
        chk($sformatf("v%0d_err", id), 32'(err_cnt - ebase), 32'(!v.ok));
        chk($sformatf("v%0d_code", id), 32'(err_code), 32'(v.code));
        chk($sformatf("v%0d_nwr", id), 32'(mon_addr.size() - wbase), 32'(v.nwr));
        for (int k = 0; k < int'(v.nwr); k++) begin
            if (wbase + k < mon_addr.size()) begin
                chk($sformatf("v%0d_addr%0d", id, k), 32'(mon_addr[wbase + k]), 32'(v.wa[k]));
                chk($sformatf("v%0d_data%0d", id, k), 32'(mon_data[wbase + k]), 32'(v.wd[k]));
                chk($sformatf("v%0d_cyc%0d", id, k), 32'(mon_cyc[wbase + k]), 32'(xfer_cyc + 1 + k));
            end
        end
        chk($sformatf("v%0d_hold", id), 32'(cpu_hold), 32'd0);
        chk($sformatf("v%0d_ready", id), 32'(rx_ready), 32'd1);
        $display("[TB] vector %0d: %0d bytes, done=%0d err=%0d code=%b writes=%0d",
                 id, v.nb, done_cnt - dbase, err_cnt - ebase, err_code, mon_addr.size() - wbase);
    endtask

    initial begin
        int n, wbase;
        logic [7:0] sum;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rst_n    = 1'b0;

        // Frame table (checksum makes COUNT+START+data+CSUM == 0 mod 256).
        vecs[0] = '{nb: 5'd8, b: 160'({8'hA5, 8'h02, 8'h04, 8'hF0, 8'h04, 8'h3C, 8'h08, 8'hC2}),
                    ok: 1'b1, code: 2'b00, nwr: 2'd2, wa: {4'h5, 4'h4}, wd: {16'h3C08, 16'hF004}};
        vecs[1] = '{nb: 5'd8, b: 160'({8'hA5, 8'h02, 8'h0F, 8'h11, 8'h11, 8'h22, 8'h22, 8'h89}),
                    ok: 1'b1, code: 2'b00, nwr: 2'd2, wa: {4'h0, 4'hF}, wd: {16'h2222, 16'h1111}};
        vecs[2] = '{nb: 5'd8, b: 160'({8'hA5, 8'h02, 8'h04, 8'hF0, 8'h04, 8'h3C, 8'h08, 8'hC3}),
                    ok: 1'b0, code: 2'b10, nwr: 2'd0, wa: '0, wd: '0};
        vecs[3] = '{nb: 5'd2, b: 160'({8'hA5, 8'h00}),
                    ok: 1'b0, code: 2'b01, nwr: 2'd0, wa: '0, wd: '0};
        vecs[4] = '{nb: 5'd2, b: 160'({8'hA5, 8'h11}),
                    ok: 1'b0, code: 2'b01, nwr: 2'd0, wa: '0, wd: '0};
        // Leading junk ignored; A5 inside the frame is ordinary data; START[7:4] ignored.
        vecs[5] = '{nb: 5'd7, b: 160'({8'h33, 8'hA5, 8'h01, 8'hA5, 8'hA5, 8'hA5, 8'h10}),
                    ok: 1'b1, code: 2'b00, nwr: 2'd1, wa: {4'h0, 4'h5}, wd: {16'h0000, 16'hA5A5}};

        #12;
        chk("rst_ready", 32'(rx_ready), 32'd1);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_addr", 32'(wr_addr), 32'd0);
        chk("rst_data", 32'(wr_data), 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd0);
        chk("rst_pulses", 32'({load_done, load_err}), 32'd0);
        chk("rst_code", 32'(err_code), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Idle timeout inside a frame.
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        chk("to_hold_during", 32'(cpu_hold), 32'd1);
        n = 0;
        while (!load_err && n < TIMEOUT + 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("to_cycles", 32'(n), 32'(TIMEOUT));
        chk("to_code", 32'(err_code), 32'b11);
        chk("to_hold", 32'(cpu_hold), 32'd0);
        $display("[TB] timeout: load_err after %0d idle cycles code=%b", n, err_code);

        // Reset during COMMIT of a 16-word frame.
        wbase = mon_addr.size();
        sum = 8'h10;
        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'h00);
        for (int k = 0; k < 16; k++) begin
            send_byte(8'(k));
            send_byte(8'(3 * k));
            sum = sum + 8'(k) + 8'(3 * k);
        end
        send_byte(8'h00 - sum);
        repeat (3) @(posedge clk);
        #2;
        chk("cm_ready_low", 32'(rx_ready), 32'd0);
        chk("cm_hold_high", 32'(cpu_hold), 32'd1);
        chk("cm_wr_en", 32'(wr_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("cm_rst_wr_en", 32'(wr_en), 32'd0);
        chk("cm_rst_hold", 32'(cpu_hold), 32'd0);
        chk("cm_rst_ready", 32'(rx_ready), 32'd1);
        chk("cm_rst_addr", 32'(wr_addr), 32'd0);
        chk("cm_rst_data", 32'(wr_data), 32'd0);
        chk("cm_partial", 32'(mon_addr.size() - wbase), 32'd2);
        if (mon_addr.size() - wbase >= 2) begin
            chk("cm_w1_addr", 32'(mon_addr[wbase + 1]), 32'd1);
            chk("cm_w1_data", 32'(mon_data[wbase + 1]), 32'h0103);
        end
        $display("[TB] reset in commit: %0d words written before reset", mon_addr.size() - wbase);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_vec(vecs[0], 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
